lpa_tile_sequencer: RTL and testbench



---
 rtl/lpa_tile_sequencer_pkg.sv | 29 ++
 rtl/axis_lane_fork.sv | 41 ++++
 rtl/lpa_tile_sequencer.sv | 131 +++++++++++++
 tb/tb_lpa_tile_sequencer.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpa_tile_sequencer_pkg.sv
// Shared types and helpers for the linear-processing-array tile sequencer.
// Holds the state encoding, a popcount helper and the result-counter width rule.
package lpa_tile_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } seq_state_e;

    localparam int POPCOUNT_MAX = 64;

    function automatic int unsigned popcount(input logic [POPCOUNT_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POPCOUNT_MAX; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    // Wide enough for tiles * PE_NUMBER_I plus one spare bit.
    function automatic int rslt_cnt_width(input int tile_width, input int pe_number_i);
        return tile_width + $clog2(pe_number_i) + 1;
    endfunction

endpackage

// File: rtl/axis_lane_fork.sv
// Broadcasts one ready/valid beat to N lanes; each lane takes the beat exactly once,
// in any order, and the upstream beat retires only when every lane has it.
module axis_lane_fork #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         s_tvalid,
    output logic         s_tready,
    output logic         beat,
    output logic [N-1:0] m_tvalid,
    input  logic [N-1:0] m_tready
);

    logic [N-1:0] sent;

    // NOTE: every output gets a value on every path, so no latch can be inferred.
    always_comb begin
        m_tvalid = '0;
        s_tready = 1'b0;
        if (en) begin
            m_tvalid = {N{s_tvalid}} & ~sent;
            s_tready = &(sent | m_tready);
        end
        beat = s_tready & s_tvalid;
    end

    // NOTE: sent is dropped whenever the fork is disabled so a later job never
    // inherits a half-delivered beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sent <= '0;
        end else if (!en || beat) begin
            sent <= '0;
        end else begin
            sent <= sent | (m_tvalid & m_tready);
        end
    end

endmodule

// File: rtl/lpa_tile_sequencer.sv
// Sequences matrix-multiply jobs: forks the left-operand stream onto the array rows,
// frames dot products with tlast/tdest and watches array results for completion or abort.
module lpa_tile_sequencer #(
    parameter int PE_NUMBER_I    = 4,
    parameter int PE_NUMBER_J    = 4,
    parameter int DATA_WIDTH_L_R = 16,
    parameter int DEST_WIDTH     = 8,
    parameter int K_WIDTH        = 16,
    parameter int TILE_WIDTH     = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [K_WIDTH-1:0]                  cfg_k_len,
    input  logic [TILE_WIDTH-1:0]               cfg_tiles,
    input  logic                                start,
    input  logic                                clr,
    output logic                                busy,
    output logic                                done,
    output logic                                error,
    input  logic [PE_NUMBER_J*DATA_WIDTH_L_R-1:0] s_axis_tdata,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    output logic [PE_NUMBER_J*DATA_WIDTH_L_R-1:0] m_axis_left_tdata,
    output logic [PE_NUMBER_J-1:0]              m_axis_left_tvalid,
    input  logic [PE_NUMBER_J-1:0]              m_axis_left_tready,
    output logic [PE_NUMBER_J-1:0]              m_axis_left_tlast,
    output logic [PE_NUMBER_J*DEST_WIDTH-1:0]   m_axis_left_tdest,
    input  logic [PE_NUMBER_I-1:0]              mon_down_tvalid,
    input  logic [PE_NUMBER_I-1:0]              mon_down_tready,
    input  logic                                err_unalligned_data,
    input  logic                                err_user_flag
);

    import lpa_tile_sequencer_pkg::*;

    localparam int RSLT_W = rslt_cnt_width(TILE_WIDTH, PE_NUMBER_I);

    seq_state_e            state, state_nxt;
    logic [K_WIDTH-1:0]    k_len_q, k_cnt;
    logic [TILE_WIDTH-1:0] tiles_q, tile_cnt;
    logic [RSLT_W-1:0]     rslt_cnt, rslt_sum, rslt_exp;
    logic                  beat, k_last, tile_last, job_last, err_in, cfg_zero;

    axis_lane_fork #(.N(PE_NUMBER_J)) u_fork (
        .clk      (clk),
        .rst      (rst),
        .en       (state == ST_RUN),
        .s_tvalid (s_axis_tvalid),
        .s_tready (s_axis_tready),
        .beat     (beat),
        .m_tvalid (m_axis_left_tvalid),
        .m_tready (m_axis_left_tready)
    );

    assign m_axis_left_tdata = s_axis_tdata;
    assign k_last            = (k_cnt == k_len_q - K_WIDTH'(1));
    assign tile_last         = (tile_cnt == tiles_q - TILE_WIDTH'(1));
    assign job_last          = beat & k_last & tile_last;
    assign m_axis_left_tlast = {PE_NUMBER_J{k_last}};
    assign m_axis_left_tdest = {PE_NUMBER_J{DEST_WIDTH'(tile_cnt)}};

    // Includes this cycle's results so DRAIN can finish on the very cycle they land.
    assign rslt_sum = rslt_cnt + RSLT_W'(popcount(POPCOUNT_MAX'(mon_down_tvalid & mon_down_tready)));
    assign rslt_exp = RSLT_W'(tiles_q) * RSLT_W'(PE_NUMBER_I);
    assign err_in   = err_unalligned_data | err_user_flag;
    assign cfg_zero = (cfg_k_len == '0) || (cfg_tiles == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = cfg_zero ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (err_in)        state_nxt = ST_ERROR;
                else if (job_last) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (err_in)                    state_nxt = ST_ERROR;
                else if (rslt_sum >= rslt_exp) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_ERROR: begin
                error = 1'b1;
                if (clr) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_len_q  <= '0;
            tiles_q  <= '0;
            k_cnt    <= '0;
            tile_cnt <= '0;
            rslt_cnt <= '0;
        end else if (state == ST_IDLE && start) begin
            k_len_q  <= cfg_k_len;
            tiles_q  <= cfg_tiles;
            k_cnt    <= '0;
            tile_cnt <= '0;
            rslt_cnt <= '0;
        end else begin
            if (state == ST_RUN || state == ST_DRAIN) rslt_cnt <= rslt_sum;
            if (beat) begin
                if (k_last) begin
                    k_cnt    <= '0;
                    tile_cnt <= tile_cnt + TILE_WIDTH'(1);
                end else begin
                    k_cnt <= k_cnt + K_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lpa_tile_sequencer.sv
// Randomized bench for lpa_tile_sequencer against a transaction-level job model
// (beats counted per job, tile = beat / K, results compared against tiles * PE_NUMBER_I).
module tb_lpa_tile_sequencer;

    localparam int PI    = 4;
    localparam int PJ    = 4;
    localparam int DW    = 16;
    localparam int DESTW = 8;
    localparam int KW    = 16;
    localparam int TW    = 16;
    localparam int LW    = PJ * DW;

    logic              clk = 1'b0;
    logic              rst;
    logic [KW-1:0]     cfg_k_len;
    logic [TW-1:0]     cfg_tiles;
    logic              start, clr;
    logic              busy, done, error;
    logic [LW-1:0]     s_axis_tdata;
    logic              s_axis_tvalid, s_axis_tready;
    logic [LW-1:0]     m_axis_left_tdata;
    logic [PJ-1:0]     m_axis_left_tvalid, m_axis_left_tready, m_axis_left_tlast;
    logic [PJ*DESTW-1:0] m_axis_left_tdest;
    logic [PI-1:0]     mon_down_tvalid, mon_down_tready;
    logic              err_unalligned_data, err_user_flag;

    always #5 clk = ~clk;

    lpa_tile_sequencer #(
        .PE_NUMBER_I(PI), .PE_NUMBER_J(PJ), .DATA_WIDTH_L_R(DW),
        .DEST_WIDTH(DESTW), .K_WIDTH(KW), .TILE_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_k_len(cfg_k_len), .cfg_tiles(cfg_tiles),
        .start(start), .clr(clr), .busy(busy), .done(done), .error(error),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_left_tdata(m_axis_left_tdata), .m_axis_left_tvalid(m_axis_left_tvalid),
        .m_axis_left_tready(m_axis_left_tready), .m_axis_left_tlast(m_axis_left_tlast),
        .m_axis_left_tdest(m_axis_left_tdest), .mon_down_tvalid(mon_down_tvalid),
        .mon_down_tready(mon_down_tready), .err_unalligned_data(err_unalligned_data),
        .err_user_flag(err_user_flag)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Job-level reference model.
    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE, M_ERROR} mphase_t;
    mphase_t     m_phase = M_IDLE;
    int          m_k, m_t, m_beats, m_results;
    bit [PJ-1:0] m_got;

    // Stimulus policy and observation counters.
    bit src_rand, rdy_rand, mon_on, src_taken;
    int mon_budget;
    int lane_hs[PJ];
    int in_hs, tready_low, done_cnt, tlast_hs, drain_obs, job_beats;
    bit any_valid, any_tready;

    task automatic clear_counters();
        for (int j = 0; j < PJ; j++) lane_hs[j] = 0;
        in_hs = 0; tready_low = 0; done_cnt = 0; tlast_hs = 0; drain_obs = 0;
        any_valid = 0; any_tready = 0; job_beats = -1;
    endtask

    task automatic model_reset();
        m_phase = M_IDLE; m_got = '0; m_beats = 0; m_results = 0; src_taken = 0;
    endtask

    task automatic drive();
        logic v, r;
        start = 1'b0; clr = 1'b0; err_unalligned_data = 1'b0; err_user_flag = 1'b0;
        if (!s_axis_tvalid || src_taken) begin
            s_axis_tvalid = src_rand ? ($urandom_range(3) != 0) : 1'b1;
            s_axis_tdata  = {$urandom, $urandom};
        end
        for (int j = 0; j < PJ; j++)
            m_axis_left_tready[j] = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
        mon_down_tvalid = '0;
        mon_down_tready = '0;
        if (mon_on && (m_phase == M_RUN || m_phase == M_DRAIN)) begin
            for (int i = 0; i < PI; i++) begin
                v = 1'($urandom_range(1));
                r = 1'($urandom_range(1));
                if (v && r) begin
                    if (mon_budget > 0) mon_budget--;
                    else r = 1'b0;
                end
                mon_down_tvalid[i] = v;
                mon_down_tready[i] = r;
            end
        end
    endtask

    // Samples the DUT mid-cycle, scores it against the model, then advances one clock.
    task automatic run_cycle();
        logic [PJ-1:0]    ev;
        logic             etr, elast;
        logic [DESTW-1:0] edest;
        int               pop;
        #1;
        ev  = '0;
        etr = 1'b0;
        if (m_phase == M_RUN) begin
            ev  = {PJ{s_axis_tvalid}} & ~m_got;
            etr = &(m_got | m_axis_left_tready);
        end
        tests_run++;
        if (busy !== (m_phase == M_RUN || m_phase == M_DRAIN) || done !== (m_phase == M_DONE) ||
            error !== (m_phase == M_ERROR)) begin
            tests_failed++;
            $display("FAIL status: busy/done/error=%b%b%b, required for phase %s", busy, done, error, m_phase.name());
        end
        tests_run++;
        if (m_axis_left_tvalid !== ev || s_axis_tready !== etr) begin
            tests_failed++;
            $display("FAIL handshake: valid=%b tready=%b, required valid=%b tready=%b", m_axis_left_tvalid, s_axis_tready, ev, etr);
        end
        tests_run++;
        if (m_axis_left_tdata !== s_axis_tdata) begin
            tests_failed++;
            $display("FAIL passthrough: data=%h, required %h", m_axis_left_tdata, s_axis_tdata);
        end
        if (m_phase == M_RUN) begin
            elast = ((m_beats % m_k) == m_k - 1);
            edest = DESTW'(m_beats / m_k);
            tests_run++;
            if (m_axis_left_tlast !== {PJ{elast}} || m_axis_left_tdest !== {PJ{edest}}) begin
                tests_failed++;
                $display("FAIL framing: beat %0d tlast=%b tdest=%h, required tlast=%b tdest=%h", m_beats, m_axis_left_tlast, m_axis_left_tdest, {PJ{elast}}, {PJ{edest}});
            end
        end

        for (int j = 0; j < PJ; j++)
            if (m_axis_left_tvalid[j] && m_axis_left_tready[j]) lane_hs[j]++;
        if (busy === 1'b1 && in_hs == job_beats) drain_obs++;
        src_taken = s_axis_tvalid && s_axis_tready;
        if (src_taken) begin
            in_hs++;
            if (m_axis_left_tlast[0]) tlast_hs++;
        end
        if (m_phase == M_RUN && s_axis_tready !== 1'b1) tready_low++;
        if (done === 1'b1) done_cnt++;
        if (|m_axis_left_tvalid) any_valid = 1;
        if (s_axis_tready === 1'b1) any_tready = 1;

        pop = $countones(mon_down_tvalid & mon_down_tready);
        case (m_phase)
            M_IDLE: if (start) begin
                m_k = int'(cfg_k_len); m_t = int'(cfg_tiles);
                m_beats = 0; m_results = 0; m_got = '0;
                m_phase = (m_k == 0 || m_t == 0) ? M_DONE : M_RUN;
            end
            M_RUN, M_DRAIN: begin
                m_results += pop;
                if (m_phase == M_RUN) begin
                    if (s_axis_tvalid && etr) begin m_beats++; m_got = '0; end
                    else m_got |= ev & m_axis_left_tready;
                end
                if (err_unalligned_data || err_user_flag) m_phase = M_ERROR;
                else if (m_phase == M_RUN) begin
                    if (m_beats == m_k * m_t) m_phase = M_DRAIN;
                end else if (m_results >= m_t * PI) m_phase = M_DONE;
            end
            M_DONE:  m_phase = M_IDLE;
            M_ERROR: begin m_got = '0; if (clr) m_phase = M_IDLE; end
            default: m_phase = M_IDLE;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic finish_job(input int limit);
        int n = 0;
        while ((m_phase != M_IDLE || busy !== 1'b0) && n < limit) begin
            drive();
            run_cycle();
            n++;
        end
        tests_run++;
        if (m_phase != M_IDLE || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL job_timeout: busy=%b after %0d cycles, required job end", busy, limit);
        end
    endtask

    task automatic start_job(input int k, input int t);
        drive();
        cfg_k_len = KW'(k);
        cfg_tiles = TW'(t);
        start     = 1'b1;
        run_cycle();
    endtask

    task automatic test_reset();
        drive();
        s_axis_tvalid = 1'b1;
        start = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            tests_run++;
            if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || s_axis_tready !== 1'b0 || m_axis_left_tvalid !== '0) begin
                tests_failed++;
                $display("FAIL reset_values: busy=%b done=%b error=%b tready=%b valid=%b, required all 0", busy, done, error, s_axis_tready, m_axis_left_tvalid);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        model_reset();
        drive();
        run_cycle();
    endtask

    task automatic test_basic();
        clear_counters();
        src_rand = 0; rdy_rand = 0; mon_on = 1; mon_budget = 2 * PI; job_beats = 6;
        start_job(3, 2);
        finish_job(200);
        tests_run++;
        if (in_hs != 6 || tlast_hs != 2 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL basic_counts: beats=%0d tlast=%0d done=%0d, required 6/2/1", in_hs, tlast_hs, done_cnt);
        end
        for (int j = 0; j < PJ; j++) begin
            tests_run++;
            if (lane_hs[j] != 6) begin
                tests_failed++;
                $display("FAIL basic_lane%0d: handshakes=%0d, required 6", j, lane_hs[j]);
            end
        end
    endtask

    task automatic test_lane_stall();
        clear_counters();
        src_rand = 0; rdy_rand = 0; mon_on = 1; mon_budget = PI;
        start_job(2, 1);
        for (int c = 1; c <= 4; c++) begin
            drive();
            m_axis_left_tready[2] = (c >= 4);
            run_cycle();
        end
        tests_run++;
        if (tready_low != 3 || in_hs != 1) begin
            tests_failed++;
            $display("FAIL stall_tready: low cycles=%0d beats=%0d, required 3/1", tready_low, in_hs);
        end
        tests_run++;
        if (lane_hs[0] != 1 || lane_hs[1] != 1 || lane_hs[2] != 1 || lane_hs[3] != 1) begin
            tests_failed++;
            $display("FAIL stall_lanes: %0d %0d %0d %0d, required 1 each", lane_hs[0], lane_hs[1], lane_hs[2], lane_hs[3]);
        end
        finish_job(200);
        tests_run++;
        if (in_hs != 2 || lane_hs[2] != 2 || lane_hs[0] != 2) begin
            tests_failed++;
            $display("FAIL stall_total: beats=%0d lane0=%0d lane2=%0d, required 2", in_hs, lane_hs[0], lane_hs[2]);
        end
    endtask

    task automatic test_zero_tiles();
        clear_counters();
        src_rand = 0; rdy_rand = 0; mon_on = 0;
        start_job(3, 0);
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_done: done=%b busy=%b, required 1/0", done, busy);
        end
        drive();
        start = 1'b1;
        run_cycle();
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_start_in_done: done=%b busy=%b, required 0/0", done, busy);
        end
        start_job(0, 3);
        finish_job(10);
        tests_run++;
        if (any_valid || any_tready || in_hs != 0 || done_cnt != 2) begin
            tests_failed++;
            $display("FAIL zero_quiet: valid_seen=%0d tready_seen=%0d beats=%0d done=%0d, required 0/0/0/2", any_valid, any_tready, in_hs, done_cnt);
        end
    endtask

    task automatic test_early_results();
        clear_counters();
        src_rand = 0; rdy_rand = 0; mon_on = 0; job_beats = 6;
        start_job(3, 2);
        for (int c = 0; c < 2; c++) begin
            drive();
            s_axis_tvalid   = 1'b0;
            mon_down_tvalid = '1;
            mon_down_tready = '1;
            run_cycle();
        end
        finish_job(100);
        tests_run++;
        if (drain_obs != 1 || done_cnt != 1 || in_hs != 6) begin
            tests_failed++;
            $display("FAIL early_drain: drain cycles=%0d done=%0d beats=%0d, required 1/1/6", drain_obs, done_cnt, in_hs);
        end
    endtask

    task automatic test_error();
        int n = 0;
        clear_counters();
        src_rand = 0; rdy_rand = 0; mon_on = 1; mon_budget = 2 * PI;
        start_job(3, 2);
        while (in_hs < 2 && n < 50) begin drive(); run_cycle(); n++; end
        drive();
        err_user_flag = 1'b1;
        run_cycle();
        tests_run++;
        if (error !== 1'b1 || busy !== 1'b0 || m_axis_left_tvalid !== '0 || s_axis_tready !== 1'b0) begin
            tests_failed++;
            $display("FAIL error_enter: error=%b busy=%b valid=%b tready=%b, required 1/0/0/0", error, busy, m_axis_left_tvalid, s_axis_tready);
        end
        for (int c = 0; c < 2; c++) begin drive(); run_cycle(); end
        drive();
        clr = 1'b1;
        run_cycle();
        drive();
        err_unalligned_data = 1'b1;
        run_cycle();
        tests_run++;
        if (error !== 1'b0 || busy !== 1'b0 || done_cnt != 0) begin
            tests_failed++;
            $display("FAIL error_clear: error=%b busy=%b done=%0d, required 0/0/0", error, busy, done_cnt);
        end
        clear_counters();
        mon_budget = 3 * PI;
        start_job(2, 3);
        tests_run++;
        if (m_axis_left_tdest !== '0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL error_restart: tdest=%h busy=%b, required 0/1", m_axis_left_tdest, busy);
        end
        finish_job(200);
        tests_run++;
        if (in_hs != 6 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL error_rerun: beats=%0d done=%0d, required 6/1", in_hs, done_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        int n = 0;
        clear_counters();
        src_rand = 0; rdy_rand = 1; mon_on = 1; mon_budget = 4 * PI;
        start_job(2, 4);
        while (in_hs < 4 && n < 200) begin drive(); run_cycle(); n++; end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || s_axis_tready !== 1'b0 || m_axis_left_tvalid !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_run: busy=%b done=%b error=%b tready=%b valid=%b, required all 0", busy, done, error, s_axis_tready, m_axis_left_tvalid);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin drive(); run_cycle(); end
        tests_run++;
        if (done_cnt != 0 || in_hs != 4) begin
            tests_failed++;
            $display("FAIL reset_no_done: done=%0d beats=%0d, required 0/4", done_cnt, in_hs);
        end
    endtask

    task automatic test_random();
        int k, t;
        for (int n = 0; n < 6; n++) begin
            k = int'($urandom_range(5, 1));
            t = int'($urandom_range(4, 1));
            clear_counters();
            src_rand = 1; rdy_rand = 1; mon_on = 1; mon_budget = t * PI; job_beats = k * t;
            start_job(k, t);
            finish_job(800);
            tests_run++;
            if (in_hs != k * t || done_cnt != 1 || tlast_hs != t) begin
                tests_failed++;
                $display("FAIL random_job%0d: beats=%0d done=%0d tlast=%0d, required %0d/1/%0d", n, in_hs, done_cnt, tlast_hs, k * t, t);
            end
            for (int j = 0; j < PJ; j++) begin
                tests_run++;
                if (lane_hs[j] != k * t) begin
                    tests_failed++;
                    $display("FAIL random_job%0d_lane%0d: handshakes=%0d, required %0d", n, j, lane_hs[j], k * t);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        cfg_k_len = '0; cfg_tiles = '0; start = 1'b0; clr = 1'b0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_left_tready = '1;
        mon_down_tvalid = '0; mon_down_tready = '0;
        err_unalligned_data = 1'b0; err_user_flag = 1'b0;
        src_rand = 0; rdy_rand = 0; mon_on = 0; mon_budget = 0;
        clear_counters();
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_lane_stall();
        test_zero_tiles();
        test_early_results();
        test_error();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required finish before 500000 time units");
        $fatal(1);
    end

endmodule
